// File: rtl/knight_tour_solver.sv
// -----------------------------------------------------------------------------
// knight_tour_solver
//
// Purpose:
//   Depth-first search with backtracking for a full knight's tour on a 5x5
//   board, starting from (x_start, y_start). The 24 moves of the tour are kept
//   as one-hot codes in a move stack that a downstream sequencer reads by index
//   after the done pulse.
//
//   Move encoding (dx,dy), north = +y:
//     b0 (-1,+2)  b1 (+1,+2)  b2 (-2,+1)  b3 (-2,-1)
//     b4 (-1,-2)  b5 (+1,-2)  b6 (+2,-1)  b7 (+2,+1)
//
// Configuration:
//   KT_PARITY_PRECHECK_EN  when defined, a go from an odd-parity start square
//                          (x_start+y_start odd) fails on the next cycle without
//                          searching, because 5x5 tours only start on even
//                          squares. When undefined the full search runs and fail
//                          is raised only once the search is exhausted.
//
// Ports:
//   clk      in  1  system clock, all flops on posedge
//   rst      in  1  asynchronous active-high reset
//   go       in  1  start-search pulse, sampled only in IDLE
//   x_start  in  3  start column 0..4 (0 = west edge)
//   y_start  in  3  start row 0..4 (0 = south edge)
//   indx     in  5  move index 0..23 to read back
//   move     out 8  one-hot move at stack[indx], combinational, 0 for indx>23
//   done     out 1  one-cycle pulse: tour found, stack valid
//   fail     out 1  one-cycle pulse: no tour from this start square
// -----------------------------------------------------------------------------
module knight_tour_solver (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [2:0] x_start,
    input  logic [2:0] y_start,
    input  logic [4:0] indx,
    output logic [7:0] move,
    output logic       done,
    output logic       fail
);

    localparam int BOARD_DIM = 5;
    localparam int NUM_MOVES = 24;
    localparam int NUM_SQ    = BOARD_DIM * BOARD_DIM;

    localparam logic [2:0] MAX_COORD = 3'(BOARD_DIM - 1);
    localparam logic [4:0] LAST_IDX  = 5'(NUM_MOVES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_POSSIBLE  = 3'd2,
        S_MAKE_MOVE = 3'd3,
        S_BACKUP    = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Column offset of move k.
    function automatic logic signed [3:0] move_dx(input logic [2:0] k);
        case (k)
            3'd0:    move_dx = -4'sd1;
            3'd1:    move_dx =  4'sd1;
            3'd2:    move_dx = -4'sd2;
            3'd3:    move_dx = -4'sd2;
            3'd4:    move_dx = -4'sd1;
            3'd5:    move_dx =  4'sd1;
            3'd6:    move_dx =  4'sd2;
            3'd7:    move_dx =  4'sd2;
            default: move_dx =  4'sd0;
        endcase
    endfunction

    // Row offset of move k.
    function automatic logic signed [3:0] move_dy(input logic [2:0] k);
        case (k)
            3'd0:    move_dy =  4'sd2;
            3'd1:    move_dy =  4'sd2;
            3'd2:    move_dy =  4'sd1;
            3'd3:    move_dy = -4'sd1;
            3'd4:    move_dy = -4'sd2;
            3'd5:    move_dy = -4'sd2;
            3'd6:    move_dy = -4'sd1;
            3'd7:    move_dy =  4'sd1;
            default: move_dy =  4'sd0;
        endcase
    endfunction

    // Linear square number y*5+x used to address the visited bitmap.
    function automatic logic [4:0] sq_index(input logic [2:0] x, input logic [2:0] y);
        sq_index = ({2'b00, y} * 5'd5) + {2'b00, x};
    endfunction

    // Lowest set bit position; also decodes a one-hot stack entry.
    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_bit = 3'(i);
            end else begin
                lowest_bit = lowest_bit;
            end
        end
    endfunction

    // Parity of the start square; odd squares cannot begin a 5x5 tour.
    function automatic logic start_parity_odd(input logic [2:0] x, input logic [2:0] y);
        start_parity_odd = x[0] ^ y[0];
    endfunction

    // Move a coordinate forward (sub=0) or back (sub=1) by a signed offset.
    function automatic logic [2:0] step_coord(input logic [2:0] c,
                                              input logic signed [3:0] off,
                                              input logic sub);
        logic signed [3:0] r;
        if (sub) begin
            r = $signed({1'b0, c}) - off;
        end else begin
            r = $signed({1'b0, c}) + off;
        end
        step_coord = r[2:0];
    endfunction

    // Moves from (cx,cy) that land on the board and on an unvisited square.
    // The bounds test comes first so an off-board target never indexes vis.
    function automatic logic [7:0] legal_moves(input logic [2:0]  cx,
                                               input logic [2:0]  cy,
                                               input logic [24:0] vis);
        logic signed [3:0] tx;
        logic signed [3:0] ty;
        legal_moves = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tx = $signed({1'b0, cx}) + move_dx(3'(k));
            ty = $signed({1'b0, cy}) + move_dy(3'(k));
            if ((tx >= 4'sd0) && (tx <= 4'sd4) && (ty >= 4'sd0) && (ty <= 4'sd4)) begin
                legal_moves[k] = ~vis[sq_index(tx[2:0], ty[2:0])];
            end else begin
                legal_moves[k] = 1'b0;
            end
        end
    endfunction

    state_t              state_q,   state_d;
    logic [NUM_SQ-1:0]   visited_q, visited_d;
    logic [7:0]          stack_q [NUM_MOVES];
    logic [7:0]          stack_d [NUM_MOVES];
    logic [7:0]          rem_q   [NUM_MOVES+1];
    logic [7:0]          rem_d   [NUM_MOVES+1];
    logic [4:0]          depth_q,   depth_d;
    logic [2:0]          cur_x_q,   cur_x_d;
    logic [2:0]          cur_y_q,   cur_y_d;
    logic                done_q,    done_d;
    logic                fail_q,    fail_d;

    logic [4:0] cur_sq_s;
    logic [7:0] legal_s;
    logic [2:0] pick_k_s;
    logic [7:0] pick_onehot_s;
    logic [2:0] fwd_x_s;
    logic [2:0] fwd_y_s;
    logic [4:0] prev_depth_s;
    logic [2:0] back_k_s;
    logic [2:0] back_x_s;
    logic [2:0] back_y_s;

    assign cur_sq_s      = sq_index(cur_x_q, cur_y_q);
    assign legal_s       = legal_moves(cur_x_q, cur_y_q, visited_q);
    assign pick_k_s      = lowest_bit(rem_q[depth_q]);
    assign pick_onehot_s = 8'h01 << pick_k_s;
    assign fwd_x_s       = step_coord(cur_x_q, move_dx(pick_k_s), 1'b0);
    assign fwd_y_s       = step_coord(cur_y_q, move_dy(pick_k_s), 1'b0);
    // Guarded so depth 0 never indexes below the stack.
    assign prev_depth_s  = (depth_q == 5'd0) ? 5'd0 : (depth_q - 5'd1);
    assign back_k_s      = lowest_bit(stack_q[prev_depth_s]);
    assign back_x_s      = step_coord(cur_x_q, move_dx(back_k_s), 1'b1);
    assign back_y_s      = step_coord(cur_y_q, move_dy(back_k_s), 1'b1);

    assign move = (indx <= LAST_IDX) ? stack_q[indx] : 8'h00;
    assign done = done_q;
    assign fail = fail_q;

    // Search FSM: next state, board/stack updates and result pulses.
    always_comb begin
        state_d   = state_q;
        visited_d = visited_q;
        stack_d   = stack_q;
        rem_d     = rem_q;
        depth_d   = depth_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        done_d    = 1'b0;
        fail_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if ((x_start > MAX_COORD) || (y_start > MAX_COORD)) begin
                        fail_d = 1'b1;
                    end
`ifdef KT_PARITY_PRECHECK_EN
                    else if (start_parity_odd(x_start, y_start)) begin
                        fail_d = 1'b1;
                    end
`endif
                    else begin
                        // Start square is latched here so INIT does not
                        // depend on x_start/y_start being held.
                        cur_x_d = x_start;
                        cur_y_d = y_start;
                        state_d = S_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_INIT: begin
                visited_d           = '0;
                visited_d[cur_sq_s] = 1'b1;
                depth_d             = 5'd0;
                for (int i = 0; i < NUM_MOVES; i++) begin
                    stack_d[i] = 8'h00;
                end
                state_d = S_POSSIBLE;
            end

            S_POSSIBLE: begin
                rem_d[depth_q] = legal_s;
                state_d        = S_MAKE_MOVE;
            end

            S_MAKE_MOVE: begin
                if (rem_q[depth_q] != 8'h00) begin
                    rem_d[depth_q]   = rem_q[depth_q] & ~pick_onehot_s;
                    stack_d[depth_q] = pick_onehot_s;
                    cur_x_d          = fwd_x_s;
                    cur_y_d          = fwd_y_s;
                    visited_d[sq_index(fwd_x_s, fwd_y_s)] = 1'b1;
                    depth_d          = depth_q + 5'd1;
                    if (depth_q == LAST_IDX) begin
                        // done is raised on entry so it is high during DONE.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_POSSIBLE;
                    end
                end else begin
                    state_d = S_BACKUP;
                end
            end

            S_BACKUP: begin
                if (depth_q == 5'd0) begin
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    visited_d[cur_sq_s]   = 1'b0;
                    cur_x_d               = back_x_s;
                    cur_y_d               = back_y_s;
                    stack_d[prev_depth_s] = 8'h00;
                    depth_d               = prev_depth_s;
                    state_d               = S_MAKE_MOVE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, board storage and output pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            visited_q <= '0;
            for (int i = 0; i < NUM_MOVES; i++) begin
                stack_q[i] <= 8'h00;
            end
            for (int i = 0; i <= NUM_MOVES; i++) begin
                rem_q[i] <= 8'h00;
            end
            depth_q   <= 5'd0;
            cur_x_q   <= 3'd0;
            cur_y_q   <= 3'd0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            visited_q <= visited_d;
            stack_q   <= stack_d;
            rem_q     <= rem_d;
            depth_q   <= depth_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

endmodule

// File: tb/tb_knight_tour_solver.sv
// -----------------------------------------------------------------------------
// tb_knight_tour_solver
//
// Self-checking bench for knight_tour_solver. Each launch runs a reference
// depth-first search in the bench (lowest move bit tried first) and pushes the
// expected outcome, tour and cycle budget onto a scoreboard queue; the scenario
// task pops it when the DUT pulses done or fail and compares.
// -----------------------------------------------------------------------------
module tb_knight_tour_solver;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [2:0] x_start;
    logic [2:0] y_start;
    logic [4:0] indx;
    logic [7:0] move;
    logic       done;
    logic       fail;

    int checks   = 0;
    int failures = 0;

    knight_tour_solver dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .x_start (x_start),
        .y_start (y_start),
        .indx    (indx),
        .move    (move),
        .done    (done),
        .fail    (fail)
    );

    always #5 clk = ~clk;

    localparam int DX [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
    localparam int DY [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

    typedef struct packed {
        logic         is_done;
        logic [191:0] stk;
        int           budget;
    } exp_t;

    exp_t         sb_q [$];
    logic [191:0] center_stk;
    logic [191:0] corner_stk;

    // Reference search: advance to the next untried legal square or retreat.
    function automatic void model_search(input int sx, input int sy,
                                         output bit found, output bit capped,
                                         output logic [191:0] stk, output int iters);
        bit vis [25];
        int px [25];
        int py [25];
        int nxt [25];
        int d, k, tx, ty;
        bit moved, over;
        stk = '0; found = 0; capped = 0; iters = 0; over = 0;
        foreach (vis[i]) vis[i] = 0;
        px[0] = sx; py[0] = sy; nxt[0] = 0; d = 0;
        vis[sy*5+sx] = 1;
        while (!over) begin
            iters++;
            if (iters > 3000000) begin
                capped = 1; over = 1;
            end else begin
                moved = 0; k = nxt[d];
                while (k < 8 && !moved) begin
                    tx = px[d] + DX[k];
                    ty = py[d] + DY[k];
                    if (tx >= 0 && tx < 5 && ty >= 0 && ty < 5 && !vis[ty*5+tx]) moved = 1;
                    else k++;
                end
                if (moved) begin
                    nxt[d] = k + 1;
                    stk[8*d +: 8] = 8'(1 << k);
                    d++;
                    px[d] = tx; py[d] = ty; nxt[d] = 0;
                    vis[ty*5+tx] = 1;
                    if (d == 24) begin found = 1; over = 1; end
                end else if (d == 0) begin
                    over = 1;
                end else begin
                    vis[py[d]*5+px[d]] = 0;
                    stk[8*(d-1) +: 8] = 8'h00;
                    d--;
                end
            end
        end
    endfunction

    // Push the expected outcome, then pulse go for one clock edge.
    task automatic launch(input int sx, input int sy, input logic [191:0] prev_stk);
        exp_t e;
        bit found, capped;
        logic [191:0] s;
        int it;
        if (sx > 4 || sy > 4) begin
            e.is_done = 1'b0; e.stk = prev_stk; e.budget = 1;
        end
`ifdef KT_PARITY_PRECHECK_EN
        else if (((sx + sy) % 2) == 1) begin
            e.is_done = 1'b0; e.stk = prev_stk; e.budget = 1;
        end
`endif
        else begin
            model_search(sx, sy, found, capped, s, it);
            e.is_done = found; e.stk = s; e.budget = 2 * it + 50;
        end
        sb_q.push_back(e);
        x_start = 3'(sx);
        y_start = 3'(sy);
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    // Observe until done/fail or budget; n=1 is the cycle right after go.
    task automatic wait_result(input int budget, input int retrig_at,
                               output bit got_done, output bit got_fail,
                               output bit both, output int n);
        got_done = 0; got_fail = 0; both = 0; n = 1;
        while (1) begin
            if (done === 1'b1 || fail === 1'b1) begin
                got_done = (done === 1'b1);
                got_fail = (fail === 1'b1);
                both     = got_done && got_fail;
                break;
            end
            if (n >= budget) break;
            if (n == retrig_at) go = 1'b1;
            @(posedge clk); #1;
            go = 1'b0;
            n++;
        end
    endtask

    task automatic read_stack(output logic [191:0] s);
        for (int i = 0; i < 24; i++) begin
            indx = 5'(i);
            #1;
            s[8*i +: 8] = move;
        end
    endtask

    // Replay a stack from (sx,sy): all moves one-hot, on board, 25 distinct squares.
    function automatic bit replay_ok(input int sx, input int sy, input logic [191:0] s);
        bit vis [25];
        int x, y, k, cnt;
        logic [7:0] m;
        foreach (vis[i]) vis[i] = 0;
        x = sx; y = sy; vis[y*5+x] = 1; cnt = 1;
        for (int i = 0; i < 24; i++) begin
            m = s[8*i +: 8];
            if (!$onehot(m)) return 0;
            k = $clog2(m);
            x = x + DX[k]; y = y + DY[k];
            if (x < 0 || x > 4 || y < 0 || y > 4) return 0;
            if (vis[y*5+x]) return 0;
            vis[y*5+x] = 1; cnt++;
        end
        return (cnt == 25);
    endfunction

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; x_start = 3'd0; y_start = 3'd0; indx = 5'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || fail !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses: done=%b fail=%b required 0 0", done, fail);
        end
        for (int i = 0; i < 32; i++) begin
            indx = 5'(i); #1;
            checks++;
            if (move !== 8'h00) begin
                failures++;
                $display("FAIL reset_move[%0d]: got %h required 00", i, move);
            end
        end
    endtask

    task automatic test_abort_reset();
        int pulses = 0;
        x_start = 3'd2; y_start = 3'd2; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || fail === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        rst = 1'b1; #1;
        for (int i = 0; i < 32; i++) begin
            indx = 5'(i); #1;
            checks++;
            if (move !== 8'h00) begin
                failures++;
                $display("FAIL abort_move[%0d]: got %h required 00", i, move);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || fail === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_pulses: got %0d pulses required 0", pulses);
        end
    endtask

    task automatic test_center();
        exp_t e;
        bit gd, gf, both;
        int n;
        logic [191:0] s;
        launch(2, 2, '0);
        wait_result(sb_q[0].budget, 0, gd, gf, both, n);
        e = sb_q.pop_front();
        checks++;
        if (gd !== e.is_done || gf !== 1'b0) begin
            failures++;
            $display("FAIL center_pulse: done=%b fail=%b after %0d cycles required done=%b fail=0",
                     gd, gf, n, e.is_done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL center_done_width: done=%b one cycle later required 0", done);
        end
        read_stack(s);
        checks++;
        if (s !== e.stk) begin
            failures++;
            $display("FAIL center_stack: got %h required %h", s, e.stk);
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (!$onehot(s[8*i +: 8])) begin
                failures++;
                $display("FAIL center_onehot[%0d]: got %h required one-hot", i, s[8*i +: 8]);
            end
        end
        checks++;
        if (!replay_ok(2, 2, s)) begin
            failures++;
            $display("FAIL center_replay: tour %h does not cover 25 squares on board", s);
        end
        center_stk = s;
    endtask

    task automatic test_bad_coord();
        exp_t e;
        bit gd, gf, both;
        int n;
        logic [191:0] s;
        launch(5, 2, center_stk);
        wait_result(sb_q[0].budget, 0, gd, gf, both, n);
        e = sb_q.pop_front();
        checks++;
        if (gf !== 1'b1 || gd !== 1'b0) begin
            failures++;
            $display("FAIL badx_pulse: fail=%b done=%b at cycle %0d required fail=1 done=0 at cycle 1",
                     gf, gd, n);
        end
        @(posedge clk); #1;
        checks++;
        if (fail !== 1'b0) begin
            failures++;
            $display("FAIL badx_fail_width: fail=%b one cycle later required 0", fail);
        end
        read_stack(s);
        checks++;
        if (s !== e.stk) begin
            failures++;
            $display("FAIL badx_stack: got %h required %h", s, e.stk);
        end
    endtask

    task automatic test_corner();
        exp_t e;
        bit gd, gf, both;
        int n;
        logic [191:0] s;
        launch(0, 0, '0);
        wait_result(sb_q[0].budget, 0, gd, gf, both, n);
        e = sb_q.pop_front();
        checks++;
        if (gd !== e.is_done || gf !== 1'b0) begin
            failures++;
            $display("FAIL corner_pulse: done=%b fail=%b after %0d cycles required done=%b fail=0",
                     gd, gf, n, e.is_done);
        end
        read_stack(s);
        checks++;
        if (s !== e.stk) begin
            failures++;
            $display("FAIL corner_stack: got %h required %h", s, e.stk);
        end
        checks++;
        if (s[7:0] !== 8'h02 && s[7:0] !== 8'h80) begin
            failures++;
            $display("FAIL corner_first_move: got %h required 02 or 80", s[7:0]);
        end
        checks++;
        if (!replay_ok(0, 0, s)) begin
            failures++;
            $display("FAIL corner_replay: tour %h does not cover 25 squares on board", s);
        end
        corner_stk = s;
    endtask

    task automatic test_retrigger();
        exp_t e;
        bit gd, gf, both;
        int n;
        int extra = 0;
        logic [191:0] s;
        launch(0, 0, '0);
        wait_result(sb_q[0].budget, 10, gd, gf, both, n);
        e = sb_q.pop_front();
        checks++;
        if (gd !== 1'b1 || gf !== 1'b0) begin
            failures++;
            $display("FAIL retrig_pulse: done=%b fail=%b after %0d cycles required done=1 fail=0",
                     gd, gf, n);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || fail === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL retrig_extra_pulse: got %0d extra pulses required 0", extra);
        end
        read_stack(s);
        checks++;
        if (s !== e.stk || s !== corner_stk) begin
            failures++;
            $display("FAIL retrig_stack: got %h required %h", s, corner_stk);
        end
    endtask

    task automatic test_odd_start();
        exp_t e;
        bit gd, gf, both, run;
        int n;
`ifdef KT_PARITY_PRECHECK_EN
        run = 1;
`else
        bit found, capped;
        logic [191:0] ms;
        int it;
        model_search(1, 0, found, capped, ms, it);
        run = !capped && (it < 20000);
        if (!run) $display("note: exhaustive search from (1,0) too long, run skipped");
`endif
        if (run) begin
            launch(1, 0, corner_stk);
            wait_result(sb_q[0].budget, 0, gd, gf, both, n);
            e = sb_q.pop_front();
            checks++;
            if (gf !== 1'b1 || gd !== 1'b0) begin
                failures++;
                $display("FAIL odd_start_pulse: fail=%b done=%b after %0d cycles required fail=1 done=0",
                         gf, gd, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_abort_reset();
        test_center();
        test_bad_coord();
        test_corner();
        test_retrigger();
        test_odd_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
